// File: rtl/piso_to_sipo_pkg.sv
// ---------------------------------------------------------------------------
// piso_to_sipo_pkg
// Shared types and constants for the parallel-in / serial-link / parallel-out
// loopback channel.
//   link_state_e  : transmit FSM state (IDLE, SHIFT)
//   DEFAULT_WIDTH : default word width in bits
// ---------------------------------------------------------------------------
package piso_to_sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } link_state_e;

    localparam int DEFAULT_WIDTH = 16;

endpackage : piso_to_sipo_pkg

// File: rtl/piso_to_sipo_if.sv
// ---------------------------------------------------------------------------
// piso_to_sipo_if
// Word-level bus of the loopback channel.
//   pin        : parallel word offered for transmission
//   load       : pin is valid this cycle
//   ready      : transmit stage accepts a word when load && ready
//   pout       : last fully received word
//   pout_valid : one-cycle strobe, pout was updated on the preceding edge
// Modports:
//   master : the word producer / consumer (drives pin and load)
//   slave  : the channel itself
// ---------------------------------------------------------------------------
interface piso_to_sipo_if
    import piso_to_sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] pin;
    logic             load;
    logic             ready;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;

    modport master (
        output pin,
        output load,
        input  ready,
        input  pout,
        input  pout_valid
    );

    modport slave (
        input  pin,
        input  load,
        output ready,
        output pout,
        output pout_valid
    );

endinterface : piso_to_sipo_if

// File: rtl/sipo_rx.sv
// ---------------------------------------------------------------------------
// sipo_rx
// Receive half of the loopback channel: collects the serial line LSB-first
// and publishes the completed word with a one-cycle valid strobe.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   serial_i     : current bit on the serial line
//   shiftEn_i    : a bit is on the line this cycle (transmitter in SHIFT)
//   lastBit_i    : this cycle carries the final bit of the word
//   pout_o       : last completed word, held until the next completion
//   poutValid_o  : pulses for one cycle after pout_o is updated
// ---------------------------------------------------------------------------
module sipo_rx
    import piso_to_sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_i,
    input  logic             shiftEn_i,
    input  logic             lastBit_i,
    output logic [WIDTH-1:0] pout_o,
    output logic             poutValid_o
);

    // Only the WIDTH-1 most recent bits need storing: the final bit is taken
    // straight off the line on the completing edge.
    logic [WIDTH-2:0] rxShreg_q, rxShreg_d;
    logic [WIDTH-1:0] assembled;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             poutValid_q, poutValid_d;

    // New bits enter at the top so the first (LSB) bit ends up at bit 0.
    always_comb begin
        assembled   = {serial_i, rxShreg_q};
        rxShreg_d   = rxShreg_q;
        pout_d      = pout_q;
        poutValid_d = 1'b0;
        if (shiftEn_i) begin
            rxShreg_d = assembled[WIDTH-1:1];
            if (lastBit_i) begin
                pout_d      = assembled;
                poutValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxShreg_q   <= '0;
            pout_q      <= '0;
            poutValid_q <= 1'b0;
        end else begin
            rxShreg_q   <= rxShreg_d;
            pout_q      <= pout_d;
            poutValid_q <= poutValid_d;
        end
    end

    assign pout_o      = pout_q;
    assign poutValid_o = poutValid_q;

endmodule : sipo_rx

// File: rtl/piso_to_sipo.sv
// ---------------------------------------------------------------------------
// piso_to_sipo
// Parallel-in, serial-link, parallel-out loopback channel. A word accepted
// on the link bus is shifted LSB-first onto an internal one-bit line and
// reassembled by sipo_rx, appearing on pout one cycle after the WIDTH-th
// shift edge. A new word may be accepted on the final shift edge so that
// back-to-back words stream without an idle bubble.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   link       : word bus (pin/load/ready/pout/pout_valid), slave side
//   serial_out : current bit on the internal serial line
//   busy       : a word is in flight
// ---------------------------------------------------------------------------
module piso_to_sipo
    import piso_to_sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    piso_to_sipo_if.slave link,
    output logic          serial_out,
    output logic          busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    link_state_e      state_q, state_d;
    logic [WIDTH-1:0] txShreg_q, txShreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serialBit;
    logic             lastBit;
    logic             shiftEn;
    logic             readyInt;
    logic [WIDTH-1:0] poutInt;
    logic             poutValidInt;

    assign lastBit = (cnt_q == LAST_CNT);
    assign shiftEn = (state_q == SHIFT);

    // Transmit FSM. On the last bit of a word the channel is ready again,
    // so a waiting word is loaded directly and SHIFT continues uninterrupted.
    always_comb begin
        state_d   = state_q;
        txShreg_d = txShreg_q;
        cnt_d     = cnt_q;
        readyInt  = 1'b0;
        serialBit = 1'b0;
        case (state_q)
            IDLE: begin
                readyInt = 1'b1;
                if (link.load) begin
                    txShreg_d = link.pin;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                serialBit = txShreg_q[0];
                txShreg_d = txShreg_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                if (lastBit) begin
                    readyInt = 1'b1;
                    cnt_d    = '0;
                    if (link.load) begin
                        txShreg_d = link.pin;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            txShreg_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            txShreg_q <= txShreg_d;
            cnt_q     <= cnt_d;
        end
    end

    sipo_rx #(
        .WIDTH (WIDTH)
    ) uRx (
        .clk         (clk),
        .rst         (rst),
        .serial_i    (serialBit),
        .shiftEn_i   (shiftEn),
        .lastBit_i   (lastBit),
        .pout_o      (poutInt),
        .poutValid_o (poutValidInt)
    );

    assign link.ready      = readyInt;
    assign link.pout       = poutInt;
    assign link.pout_valid = poutValidInt;
    assign serial_out      = serialBit;
    assign busy            = shiftEn;

endmodule : piso_to_sipo

// File: tb/tb_piso_to_sipo.sv
// ---------------------------------------------------------------------------
// tb_piso_to_sipo
// Directed bench for piso_to_sipo: a WIDTH=16 instance for the main
// sequence and a WIDTH=4 instance for the narrow-word case, sharing clock
// and reset. Inputs change 1 time unit after a rising edge; outputs are
// observed at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_piso_to_sipo;

    logic clk;
    logic rst;
    logic serialOut16, busy16;
    logic serialOut4, busy4;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    piso_to_sipo_if #(.WIDTH(16)) link16 ();
    piso_to_sipo_if #(.WIDTH(4))  link4 ();

    piso_to_sipo #(.WIDTH(16)) uDut16 (
        .clk        (clk),
        .rst        (rst),
        .link       (link16.slave),
        .serial_out (serialOut16),
        .busy       (busy16)
    );

    piso_to_sipo #(.WIDTH(4)) uDut4 (
        .clk        (clk),
        .rst        (rst),
        .link       (link4.slave),
        .serial_out (serialOut4),
        .busy       (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] pin16, input logic load16,
                                 input logic [3:0] pin4, input logic load4);
        link16.pin  = pin16;
        link16.load = load16;
        link4.pin   = pin4;
        link4.load  = load4;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [15:0] expSerial;

        rst = 1'b0;
        applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
        #2;
        checkOutput("reset_ready",  32'(link16.ready), 32'd1);
        checkOutput("reset_busy",   32'(busy16), 32'd0);
        checkOutput("reset_serial", 32'(serialOut16), 32'd0);
        checkOutput("reset_pout",   32'(link16.pout), 32'd0);
        checkOutput("reset_valid",  32'(link16.pout_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("idle_serial", 32'(serialOut16), 32'd0);
        checkOutput("idle_ready",  32'(link16.ready), 32'd1);

        // Single word 16'hA5C3, LSB first on the line.
        $display("[TB] single word");
        expSerial = 16'b1010_0101_1100_0011;
        applyStimulus(16'hA5C3, 1'b1, 4'h0, 1'b0);
        tick();
        applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
        checkOutput("single_busy",  32'(busy16), 32'd1);
        checkOutput("single_ready", 32'(link16.ready), 32'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("single_bit%0d", i), 32'(serialOut16), 32'(expSerial[i]));
            checkOutput($sformatf("single_novalid%0d", i), 32'(link16.pout_valid), 32'd0);
            tick();
        end
        checkOutput("single_valid", 32'(link16.pout_valid), 32'd1);
        checkOutput("single_pout",  32'(link16.pout), 32'h0000A5C3);
        checkOutput("single_idle",  32'(busy16), 32'd0);
        tick();
        checkOutput("single_pulse_end", 32'(link16.pout_valid), 32'd0);
        checkOutput("single_hold",      32'(link16.pout), 32'h0000A5C3);

        // Back-to-back: second word waits with load held until ready.
        $display("[TB] back-to-back");
        applyStimulus(16'h0001, 1'b1, 4'h0, 1'b0);
        tick();
        applyStimulus(16'hFFFF, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("b2b_busy_a%0d", i), 32'(busy16), 32'd1);
            checkOutput($sformatf("b2b_notready%0d", i), 32'(link16.ready), 32'd0);
            tick();
        end
        checkOutput("b2b_ready_last", 32'(link16.ready), 32'd1);
        tick();
        applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
        checkOutput("b2b_valid1", 32'(link16.pout_valid), 32'd1);
        checkOutput("b2b_pout1",  32'(link16.pout), 32'h00000001);
        checkOutput("b2b_busy_mid", 32'(busy16), 32'd1);
        tick();
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("b2b_busy_b%0d", i), 32'(busy16), 32'd1);
            checkOutput($sformatf("b2b_novalid%0d", i), 32'(link16.pout_valid), 32'd0);
            tick();
        end
        checkOutput("b2b_valid2", 32'(link16.pout_valid), 32'd1);
        checkOutput("b2b_pout2",  32'(link16.pout), 32'h0000FFFF);
        checkOutput("b2b_done",   32'(busy16), 32'd0);
        tick();

        // Load while busy is ignored.
        $display("[TB] ignored load");
        applyStimulus(16'h00FF, 1'b1, 4'h0, 1'b0);
        tick();
        applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
        repeat (5) tick();
        applyStimulus(16'h1234, 1'b1, 4'h0, 1'b0);
        checkOutput("ign_ready", 32'(link16.ready), 32'd0);
        tick();
        applyStimulus(16'h1234, 1'b0, 4'h0, 1'b0);
        repeat (10) tick();
        checkOutput("ign_valid", 32'(link16.pout_valid), 32'd1);
        checkOutput("ign_pout",  32'(link16.pout), 32'h000000FF);
        tick();
        checkOutput("ign_idle",  32'(busy16), 32'd0);
        checkOutput("ign_novalid", 32'(link16.pout_valid), 32'd0);

        // Reset in the middle of 16'hBEEF.
        $display("[TB] reset mid-transfer");
        applyStimulus(16'hBEEF, 1'b1, 4'h0, 1'b0);
        tick();
        applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
        repeat (8) tick();
        checkOutput("mid_busy_before", 32'(busy16), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_pout",   32'(link16.pout), 32'd0);
        checkOutput("mid_busy",   32'(busy16), 32'd0);
        checkOutput("mid_ready",  32'(link16.ready), 32'd1);
        checkOutput("mid_serial", 32'(serialOut16), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("mid_novalid%0d", i), 32'(link16.pout_valid), 32'd0);
        end
        applyStimulus(16'h5A5A, 1'b1, 4'h0, 1'b0);
        tick();
        applyStimulus(16'h0000, 1'b0, 4'h0, 1'b0);
        repeat (16) tick();
        checkOutput("after_valid", 32'(link16.pout_valid), 32'd1);
        checkOutput("after_pout",  32'(link16.pout), 32'h00005A5A);
        tick();

        // Narrow instance: 4'b1001 emerges four edges after acceptance.
        $display("[TB] width 4");
        applyStimulus(16'h0000, 1'b0, 4'b1001, 1'b1);
        tick();
        applyStimulus(16'h0000, 1'b0, 4'b0000, 1'b0);
        checkOutput("w4_busy", 32'(busy4), 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("w4_novalid%0d", i), 32'(link4.pout_valid), 32'd0);
            tick();
        end
        checkOutput("w4_novalid3", 32'(link4.pout_valid), 32'd0);
        tick();
        checkOutput("w4_valid", 32'(link4.pout_valid), 32'd1);
        checkOutput("w4_pout",  32'(link4.pout), 32'h00000009);
        checkOutput("w4_idle",  32'(busy4), 32'd0);
        tick();
        checkOutput("w4_pulse_end", 32'(link4.pout_valid), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_piso_to_sipo
